// File: rtl/jam_cost_server_pkg.sv
// -----------------------------------------------------------------------------
// jam_cost_server_pkg
// Purpose : Shared constants, the server FSM state type and a small helper for
//           the W/J -> Cost lookup server.
// Contents: COST_W, N, IDX_W, ADDR_W, DEPTH, RES_W, MATCH_W, jam_srv_state_t,
//           cost_min().
// -----------------------------------------------------------------------------
package jam_cost_server_pkg;

    localparam int COST_W  = 7;            // width of one cost entry
    localparam int N       = 8;            // workers = jobs
    localparam int IDX_W   = 3;            // width of W and J
    localparam int ADDR_W  = 2 * IDX_W;    // matrix entry address {W,J}
    localparam int DEPTH   = N * N;        // number of matrix entries
    localparam int RES_W   = 10;           // width of MinCost
    localparam int MATCH_W = 4;            // width of MatchCount

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } jam_srv_state_t;

    function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] a,
                                                    input logic [COST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/jam_cost_server_if.sv
// -----------------------------------------------------------------------------
// jam_cost_server_if
// Purpose : Bundles the load stream, the solver lookup/result signals and the
//           status outputs of jam_cost_server.
// Modports: master - host loader + solver side (drives LD_*, W, J, Valid,
//                    MinCost, MatchCount)
//           slave  - the cost server (drives LD_READY, JAM_RST, Cost, DONE,
//                    TIMEOUT, RES_MINCOST, RES_MATCH, LB_ERR)
// -----------------------------------------------------------------------------
interface jam_cost_server_if;

    // load stream
    logic                                          LD_VALID;
    logic [jam_cost_server_pkg::COST_W-1:0]        LD_DATA;
    logic                                          LD_READY;
    // solver control and lookup
    logic                                          JAM_RST;
    logic [jam_cost_server_pkg::IDX_W-1:0]         W;
    logic [jam_cost_server_pkg::IDX_W-1:0]         J;
    logic [jam_cost_server_pkg::COST_W-1:0]        Cost;
    // solver result
    logic                                          Valid;
    logic [jam_cost_server_pkg::RES_W-1:0]         MinCost;
    logic [jam_cost_server_pkg::MATCH_W-1:0]       MatchCount;
    // status
    logic                                          DONE;
    logic                                          TIMEOUT;
    logic [jam_cost_server_pkg::RES_W-1:0]         RES_MINCOST;
    logic [jam_cost_server_pkg::MATCH_W-1:0]       RES_MATCH;
    logic                                          LB_ERR;

    modport master (
        output LD_VALID, LD_DATA, W, J, Valid, MinCost, MatchCount,
        input  LD_READY, JAM_RST, Cost, DONE, TIMEOUT, RES_MINCOST, RES_MATCH, LB_ERR
    );

    modport slave (
        input  LD_VALID, LD_DATA, W, J, Valid, MinCost, MatchCount,
        output LD_READY, JAM_RST, Cost, DONE, TIMEOUT, RES_MINCOST, RES_MATCH, LB_ERR
    );

endinterface

// File: rtl/jam_cost_server_ram.sv
// -----------------------------------------------------------------------------
// jam_cost_server_ram
// Purpose : 64 x COST_W cost matrix storage with one synchronous write port and
//           one registered read port (1-cycle read latency).
// Ports   : clk, rst_n      clock / async active-low reset (read register only)
//           we_i, waddr_i, wdata_i   write port
//           raddr_i, rdata_o         registered read port
// A read of the entry being written in the same cycle returns the old value.
// The storage itself is not reset.
// -----------------------------------------------------------------------------
module jam_cost_server_ram
    import jam_cost_server_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [COST_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [COST_W-1:0] rdata_o
);

    logic [COST_W-1:0] mem_q [DEPTH];
    logic [COST_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jam_cost_server.sv
// -----------------------------------------------------------------------------
// jam_cost_server
// Purpose : Responder side of the solver's W/J -> Cost lookup. Loads the 8x8
//           cost matrix from a valid/ready stream (row-major, entry = W*8+J),
//           holds the solver in reset while loading, releases it, answers every
//           lookup with a registered Cost and captures the solver result when
//           Valid rises, with a watchdog that declares TIMEOUT.
// Ports   : CLK, RST_N (async active-low), srv (jam_cost_server_if.slave)
// Params  : KICK_CYC    cycles JAM_RST stays high in KICK before release
//           TO_W        watchdog width
//           TIMEOUT_CYC RUN cycles before TIMEOUT
// Option  : JAM_COST_LB_CHECK_EN - when defined, a lower bound (sum of row
//           minima) is built during load and LB_ERR flags MinCost < bound.
//           Undefined: LB_ERR is tied low.
// -----------------------------------------------------------------------------
module jam_cost_server
    import jam_cost_server_pkg::*;
#(
    parameter int KICK_CYC    = 2,
    parameter int TO_W        = 20,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic              CLK,
    input  logic              RST_N,
    jam_cost_server_if.slave  srv
);

    localparam int KICK_W = (KICK_CYC < 1) ? 1 : $clog2(KICK_CYC + 1);

    jam_srv_state_t     state_q;
    logic [ADDR_W-1:0]  ld_cnt_q;
    logic [KICK_W-1:0]  kick_q;
    logic [TO_W-1:0]    wd_q;
    logic               ld_ready_q;
    logic               jam_rst_q;
    logic               done_q;
    logic               timeout_q;
    logic [RES_W-1:0]   res_min_q;
    logic [MATCH_W-1:0] res_match_q;

    logic accept;
    logic last_word;
    logic capture;
    logic reload;

    // ld_ready_q is only ever high in LOAD, so it alone qualifies a write.
    assign accept    = srv.LD_VALID && ld_ready_q;
    assign last_word = (ld_cnt_q == ADDR_W'(DEPTH - 1));
    assign capture   = (state_q == RUN) && srv.Valid;
    assign reload    = (state_q == DONE) && srv.LD_VALID;

    jam_cost_server_ram u_ram (
        .clk     (CLK),
        .rst_n   (RST_N),
        .we_i    (accept),
        .waddr_i (ld_cnt_q),
        .wdata_i (srv.LD_DATA),
        .raddr_i ({srv.W, srv.J}),
        .rdata_o (srv.Cost)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= LOAD;
            ld_cnt_q    <= '0;
            kick_q      <= '0;
            wd_q        <= '0;
            ld_ready_q  <= 1'b0;
            jam_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            res_min_q   <= '1;
            res_match_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    jam_rst_q <= 1'b1;
                    // Ready comes up one cycle after reset and drops right
                    // after the final word is taken.
                    ld_ready_q <= !(accept && last_word);
                    if (accept) begin
                        ld_cnt_q <= ld_cnt_q + ADDR_W'(1);
                        if (last_word) begin
                            state_q <= KICK;
                            kick_q  <= '0;
                        end
                    end
                end
                KICK: begin
                    // The accept cycle plus KICK_CYC counted cycles keep the
                    // solver in reset; it sees JAM_RST low KICK_CYC+1 edges
                    // after the last accept.
                    if (kick_q == KICK_W'(KICK_CYC)) begin
                        state_q   <= RUN;
                        jam_rst_q <= 1'b0;
                        wd_q      <= '0;
                    end else begin
                        kick_q <= kick_q + KICK_W'(1);
                    end
                end
                RUN: begin
                    wd_q <= wd_q + TO_W'(1);
                    // Valid takes priority over a simultaneous expiry.
                    if (srv.Valid) begin
                        res_min_q   <= srv.MinCost;
                        res_match_q <= srv.MatchCount;
                        done_q      <= 1'b1;
                        jam_rst_q   <= 1'b1;
                        state_q     <= DONE;
                    end else if (wd_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        jam_rst_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // The word that triggers the reload is only a request; it
                    // is not written because LD_READY is low this cycle.
                    if (srv.LD_VALID) begin
                        state_q    <= LOAD;
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        ld_ready_q <= 1'b1;
                        ld_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign srv.LD_READY    = ld_ready_q;
    assign srv.JAM_RST     = jam_rst_q;
    assign srv.DONE        = done_q;
    assign srv.TIMEOUT     = timeout_q;
    assign srv.RES_MINCOST = res_min_q;
    assign srv.RES_MATCH   = res_match_q;

`ifdef JAM_COST_LB_CHECK_EN
    logic [COST_W-1:0] row_min_q;
    logic [COST_W-1:0] row_min_d;
    logic [RES_W-1:0]  lb_q;
    logic              lb_err_q;

    // Column 0 starts a fresh row minimum.
    assign row_min_d = (ld_cnt_q[IDX_W-1:0] == '0) ? srv.LD_DATA
                                                    : cost_min(row_min_q, srv.LD_DATA);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_min_q <= '0;
            lb_q      <= '0;
            lb_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                row_min_q <= row_min_d;
                // End of each row folds its minimum into the bound; row 0
                // restarts the sum so a reload never inherits the old bound.
                if (ld_cnt_q[IDX_W-1:0] == '1) begin
                    lb_q <= ((ld_cnt_q[ADDR_W-1:IDX_W] == '0) ? '0 : lb_q)
                            + RES_W'(row_min_d);
                end
            end
            if (reload) begin
                lb_err_q <= 1'b0;
            end else if (capture) begin
                lb_err_q <= (srv.MinCost < lb_q);
            end
        end
    end

    assign srv.LB_ERR = lb_err_q;
`else
    assign srv.LB_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
module tb_jam_cost_server;
    import jam_cost_server_pkg::*;

    localparam int TB_KICK = 2;
    localparam int TB_TO   = 100;
`ifdef JAM_COST_LB_CHECK_EN
    localparam bit LB_ON = 1'b1;
`else
    localparam bit LB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jam_cost_server_if ifc ();

    jam_cost_server #(
        .KICK_CYC    (TB_KICK),
        .TO_W        (20),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .srv   (ifc.slave)
    );

    int total = 0;
    int bad   = 0;

    // reference model: matrix contents and result registers
    logic [6:0] mdl     [64];
    bit         mdl_ok  [64];
    logic [6:0] nxt     [64];
    int         res_min_m;
    int         res_match_m;
    bit         lb_err_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lb_model();
        int s;
        int m;
        s = 0;
        for (int r = 0; r < 8; r++) begin
            m = int'(mdl[r*8]);
            for (int c = 1; c < 8; c++) begin
                if (int'(mdl[r*8+c]) < m) m = int'(mdl[r*8+c]);
            end
            s += m;
        end
        return s;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.LD_VALID = 1'b0;
        ifc.Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ld_ready", 32'(ifc.LD_READY), 0);
        check_eq("rst_jam_rst", 32'(ifc.JAM_RST), 1);
        check_eq("rst_cost", 32'(ifc.Cost), 0);
        check_eq("rst_done", 32'(ifc.DONE), 0);
        check_eq("rst_timeout", 32'(ifc.TIMEOUT), 0);
        check_eq("rst_res_min", 32'(ifc.RES_MINCOST), 1023);
        check_eq("rst_res_match", 32'(ifc.RES_MATCH), 0);
        check_eq("rst_lb_err", 32'(ifc.LB_ERR), 0);
        rst_n = 1'b1;
        res_min_m = 1023;
        res_match_m = 0;
        lb_err_m = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_ld_ready", 32'(ifc.LD_READY), 1);
        check_eq("post_rst_jam_rst", 32'(ifc.JAM_RST), 1);
        $display("reset applied");
    endtask

    // Offer words nxt[start..stop-1]; each cycle also checks one lookup.
    task automatic load_matrix(input int start, input int stop, input bit gaps,
                               input bit rdw, output int accepts);
        int k;
        int cyc;
        bit acc;
        logic [5:0] ra;
        k = start;
        cyc = 0;
        accepts = 0;
        while (k < stop) begin
            if (cyc > 1000) begin
                check_eq("load_budget", 32'(k), 32'(stop));
                break;
            end
            ifc.LD_VALID = gaps ? cyc[0] : 1'b1;
            ifc.LD_DATA = nxt[k];
            ra = rdw ? 6'(k) : 6'($urandom);
            ifc.W = ra[5:3];
            ifc.J = ra[2:0];
            acc = ifc.LD_VALID && ifc.LD_READY;
            @(posedge clk);
            #1;
            if (mdl_ok[ra]) check_eq(rdw ? "rdw_old_value" : "load_read", 32'(ifc.Cost), 32'(mdl[ra]));
            if (acc) begin
                mdl[k] = nxt[k];
                mdl_ok[k] = 1'b1;
                k++;
                accepts++;
            end
            cyc++;
        end
        ifc.LD_VALID = 1'b0;
        $display("load words %0d..%0d accepts=%0d cycles=%0d", start, stop - 1, accepts, cyc);
    endtask

    task automatic wait_run(input bit offer, input int raddr);
        int n;
        int extra;
        bit acc;
        logic [5:0] a;
        a = 6'(raddr);
        ifc.W = a[5:3];
        ifc.J = a[2:0];
        check_eq("ld_ready_after_load", 32'(ifc.LD_READY), 0);
        n = 0;
        extra = 0;
        ifc.LD_VALID = offer;
        do begin
            acc = ifc.LD_VALID && ifc.LD_READY;
            @(posedge clk);
            #1;
            n++;
            if (acc) extra++;
        end while (ifc.JAM_RST && n < 20);
        ifc.LD_VALID = 1'b0;
        check_eq("kick_len", 32'(n), 32'(TB_KICK + 1));
        check_eq("kick_extra_accepts", 32'(extra), 0);
        check_eq("kick_read", 32'(ifc.Cost), 32'(mdl[a]));
        $display("release after %0d cycles, read entry %0d = %0h", n, raddr, ifc.Cost);
    endtask

    // valid_at: RUN cycle (0 = first released cycle) where Valid is raised.
    task automatic run_phase(input int valid_at, input int minc, input int matchc);
        int done_cyc;
        bit to;
        logic [5:0] a;
        done_cyc = (valid_at < TB_TO) ? valid_at : TB_TO - 1;
        to = (valid_at >= TB_TO);
        for (int c = 0; c <= done_cyc; c++) begin
            a = (c < 64) ? 6'(c) : 6'($urandom);
            ifc.W = a[5:3];
            ifc.J = a[2:0];
            ifc.Valid = (c == valid_at);
            ifc.MinCost = (c == valid_at) ? 10'(minc) : 10'($urandom);
            ifc.MatchCount = (c == valid_at) ? 4'(matchc) : 4'($urandom);
            @(posedge clk);
            #1;
            check_eq("run_cost", 32'(ifc.Cost), 32'(mdl[a]));
            if (c < done_cyc) check_eq("done_early", 32'(ifc.DONE), 0);
        end
        ifc.Valid = 1'b0;
        if (!to) begin
            res_min_m = minc;
            res_match_m = matchc;
            lb_err_m = LB_ON ? (minc < lb_model()) : 1'b0;
        end
        check_eq("done", 32'(ifc.DONE), 1);
        check_eq("timeout", 32'(ifc.TIMEOUT), 32'(to));
        check_eq("res_mincost", 32'(ifc.RES_MINCOST), 32'(res_min_m));
        check_eq("res_match", 32'(ifc.RES_MATCH), 32'(res_match_m));
        check_eq("lb_err", 32'(ifc.LB_ERR), 32'(lb_err_m));
        check_eq("done_jam_rst", 32'(ifc.JAM_RST), 1);
        @(posedge clk);
        #1;
        check_eq("done_hold", 32'(ifc.DONE), 1);
        check_eq("done_ld_ready", 32'(ifc.LD_READY), 0);
        $display("run valid_at=%0d done_cyc=%0d timeout=%0d res=%0d/%0d lb_err=%0d",
                 valid_at, done_cyc, ifc.TIMEOUT, ifc.RES_MINCOST, ifc.RES_MATCH, ifc.LB_ERR);
    endtask

    task automatic restart();
        ifc.LD_VALID = 1'b1;
        ifc.LD_DATA = 7'h7F;
        @(posedge clk);
        #1;
        ifc.LD_VALID = 1'b0;
        lb_err_m = 1'b0;
        check_eq("restart_done", 32'(ifc.DONE), 0);
        check_eq("restart_timeout", 32'(ifc.TIMEOUT), 0);
        check_eq("restart_lb_err", 32'(ifc.LB_ERR), 0);
        check_eq("restart_ld_ready", 32'(ifc.LD_READY), 1);
        $display("reload requested from DONE");
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) nxt[i] = 7'($urandom);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 64; i++) nxt[i] = 7'(v);
    endtask

    initial begin
        int acc_n;
        for (int i = 0; i < 64; i++) begin
            mdl[i] = '0;
            mdl_ok[i] = 1'b0;
        end
        ifc.LD_VALID = 1'b0;
        ifc.LD_DATA = '0;
        ifc.W = '0;
        ifc.J = '0;
        ifc.Valid = 1'b0;
        ifc.MinCost = '0;
        ifc.MatchCount = '0;
        @(posedge clk);
        #1;
        do_reset();

        // 1) plain load, entry 29 = 0x2A, read back W=3,J=5
        fill_random();
        nxt[29] = 7'h2A;
        load_matrix(0, 64, 1'b0, 1'b0, acc_n);
        check_eq("t1_accepts", 32'(acc_n), 64);
        wait_run(1'b0, 29);
        check_eq("t1_cost_w3_j5", 32'(ifc.Cost), 32'h2A);
        run_phase(int'($urandom_range(5, 60)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)));

        // 2) gapped load with read-during-write, extra word offered in KICK; timeout keeps results
        restart();
        fill_random();
        load_matrix(0, 64, 1'b1, 1'b1, acc_n);
        check_eq("t2_accepts", 32'(acc_n), 64);
        wait_run(1'b1, int'($urandom_range(0, 63)));
        run_phase(TB_TO + 50, 0, 0);

        // 3) diagonal matrix, solver reports MinCost=0, MatchCount=1
        restart();
        for (int i = 0; i < 64; i++) nxt[i] = ((i / 8) == (i % 8)) ? 7'd0 : 7'd10;
        load_matrix(0, 64, 1'b0, 1'b1, acc_n);
        wait_run(1'b0, 9);
        run_phase(20, 0, 1);

        // 4) reset after word 30, then full reload; Valid on the expiry cycle wins
        restart();
        fill_random();
        load_matrix(0, 31, 1'b0, 1'b0, acc_n);
        do_reset();
        fill_random();
        load_matrix(0, 63, 1'b1, 1'b0, acc_n);
        check_eq("t4_ready_after_63", 32'(ifc.LD_READY), 1);
        check_eq("t4_jam_rst_after_63", 32'(ifc.JAM_RST), 1);
        load_matrix(63, 64, 1'b0, 1'b0, acc_n);
        wait_run(1'b0, 63);
        run_phase(TB_TO - 1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)));

        // 5) timeout straight after reset: results keep reset values
        do_reset();
        fill_random();
        load_matrix(0, 64, 1'b0, 1'b0, acc_n);
        wait_run(1'b0, 0);
        run_phase(TB_TO + 10, 0, 0);

        // 6) lower bound: all costs 1 -> bound 8
        restart();
        fill_const(1);
        load_matrix(0, 64, 1'b0, 1'b0, acc_n);
        wait_run(1'b0, 40);
        run_phase(10, 5, 3);
        restart();
        load_matrix(0, 64, 1'b1, 1'b0, acc_n);
        wait_run(1'b0, 41);
        run_phase(12, 8, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
